// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path: segment bit positions,
// the legal digit codes (bit6=g .. bit0=a) and the decoder FSM states.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h67;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [0:0] {
      TRACK = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_lut.sv
// Combinational segment-pattern to digit lookup; anything that is neither a
// digit code nor all-off is reported as invalid with digit forced to zero.
module seg7_lut
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       blank,
   output logic       invalid
);

   // Decode one pattern into digit / blank / invalid.
   always_comb begin
      digit   = 4'd0;
      blank   = 1'b0;
      invalid = 1'b0;
      case (pattern)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: blank = 1'b1;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Receive side of the 7-segment bus: synchronise, wait for a settled pattern,
// decode it and hand each new settled pattern out once over valid/ready.
module seg7_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int ERR_W         = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       seg_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [3:0]       digit,
   output logic             blank,
   output logic             invalid,
   output logic [ERR_W-1:0] err_count
);

   localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [6:0]       s1_q, s2_q;
   logic [6:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_e           state_q, state_d;
   logic [6:0]       pat_q, pat_d;
   logic [6:0]       last_q, last_d;
   logic             last_vld_q, last_vld_d;
   logic             valid_q, valid_d;
   logic [3:0]       digit_q, digit_d;
   logic             blank_q, blank_d;
   logic             inv_q, inv_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [3:0]       lut_digit_s;
   logic             lut_blank_s, lut_invalid_s;
   logic             settled_s, fresh_s;

   seg7_lut u_lut (
      .pattern (cand_q),
      .digit   (lut_digit_s),
      .blank   (lut_blank_s),
      .invalid (lut_invalid_s)
   );

   assign settled_s = (cnt_q == CNT_MAX);
   assign fresh_s   = settled_s && (!last_vld_q || (cand_q != last_q));

   // Stability tracker: restart on any change, otherwise count up to the limit.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Emit/hold FSM; outputs only change on emission and on acceptance.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      valid_d    = valid_q;
      digit_d    = digit_q;
      blank_d    = blank_q;
      inv_d      = inv_q;
      err_d      = err_q;
      case (state_q)
         TRACK: begin
            if (fresh_s) begin
               state_d = HOLD;
               valid_d = 1'b1;
               pat_d   = cand_q;
               digit_d = lut_digit_s;
               blank_d = lut_blank_s;
               inv_d   = lut_invalid_s;
            end else begin
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d    = TRACK;
               valid_d    = 1'b0;
               last_d     = pat_q;
               last_vld_d = 1'b1;
               if (inv_q && (err_q != {ERR_W{1'b1}})) begin
                  err_d = err_q + ERR_W'(1);
               end else begin
                  err_d = err_q;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = TRACK;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers: two-flop synchroniser, tracker and FSM/output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 7'h00;
         s2_q       <= 7'h00;
         cand_q     <= 7'h00;
         cnt_q      <= '0;
         state_q    <= TRACK;
         pat_q      <= 7'h00;
         last_q     <= 7'h00;
         last_vld_q <= 1'b0;
         valid_q    <= 1'b0;
         digit_q    <= 4'd0;
         blank_q    <= 1'b0;
         inv_q      <= 1'b0;
         err_q      <= '0;
      end else begin
         s1_q       <= seg_in;
         s2_q       <= s1_q;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         pat_q      <= pat_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         valid_q    <= valid_d;
         digit_q    <= digit_d;
         blank_q    <= blank_d;
         inv_q      <= inv_d;
         err_q      <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign digit     = digit_q;
   assign blank     = blank_q;
   assign invalid   = inv_q;
   assign err_count = err_q;

endmodule
